// File: rtl/register_column_burst_ctrl_pkg.sv
// register_column_pkg: shared types and sizing for the register column burst controller.
package register_column_pkg;
    localparam int COL_ELEM_WIDTH = 8;
    localparam int COL_ADDR_WIDTH = 10;
    localparam int DEPTH = 2**COL_ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
endpackage

// File: rtl/register_column_burst_ctrl_if.sv
// register_column_burst_ctrl_if: command, stream and column-port bundle.
// The slave modport is the controller's view; master is the upstream/column side.
interface register_column_burst_ctrl_if
    import register_column_pkg::*;
#(
    parameter int ELEM_WIDTH = COL_ELEM_WIDTH,
    parameter int ADDR_WIDTH = COL_ADDR_WIDTH
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [ADDR_WIDTH-1:0] cmd_len_i;
    logic [ELEM_WIDTH-1:0] wdata_i;
    logic                  wvalid_i;
    logic                  wready_o;
    logic [ELEM_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [ELEM_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic [ELEM_WIDTH-1:0] mem_rdata_i;
    logic                  done_o;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, wdata_i, wvalid_i, rready_i, mem_rdata_i,
        output cmd_ready_o, wready_o, rdata_o, rvalid_o, mem_addr_o, mem_wdata_o, mem_we_o, done_o
    );
    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, wdata_i, wvalid_i, rready_i, mem_rdata_i,
        input  cmd_ready_o, wready_o, rdata_o, rvalid_o, mem_addr_o, mem_wdata_o, mem_we_o, done_o
    );
endinterface

// File: rtl/register_column_burst_ctrl.sv
// register_column_burst_ctrl: read/write burst initiator for the register column,
// streaming write beats in and registered read beats out over valid/ready.
module register_column_burst_ctrl
    import register_column_pkg::*;
#(
    parameter int ELEM_WIDTH = COL_ELEM_WIDTH,
    parameter int ADDR_WIDTH = COL_ADDR_WIDTH
) (
    input logic clk_i,
    input logic arst_ni,
    register_column_burst_ctrl_if.slave bus
);
    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_rem;
    logic                  r_fetch_done;
    logic                  r_rvalid;
    logic [ELEM_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  w_cmd_fire;
    logic                  w_wfire;
    logic                  w_wlast;
    logic                  w_fetch;
    logic                  w_rlast;

    always_comb begin
        w_cmd_fire  = r_state == IDLE && bus.cmd_valid_i;
        w_wfire     = r_state == WRITE && bus.wvalid_i;
        w_wlast     = w_wfire && r_rem == '0;
        w_fetch     = r_state == READ && (!r_rvalid || bus.rready_i) && !r_fetch_done;
        w_rlast     = r_state == READ && r_rvalid && bus.rready_i && r_fetch_done;
        w_state_nxt = w_cmd_fire ? (bus.cmd_write_i ? WRITE : READ)
                    : (w_wlast || w_rlast) ? IDLE : r_state;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Write beats and read fetches share the pointer/counter; the read output
    // register acts as a one-deep skid so a stalled beat is never refetched.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ptr        <= '0;
            r_rem        <= '0;
            r_fetch_done <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_ptr        <= bus.cmd_addr_i;
                r_rem        <= bus.cmd_len_i;
                r_fetch_done <= 1'b0;
            end else if (w_wfire || w_fetch) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_rem != '0)
                    r_rem <= r_rem - 1'b1;
            end
            if (w_fetch && r_rem == '0)
                r_fetch_done <= 1'b1;
            if (w_fetch) begin
                r_rdata  <= bus.mem_rdata_i;
                r_rvalid <= 1'b1;
            end else if (r_rvalid && bus.rready_i) begin
                r_rvalid <= 1'b0;
            end
            r_done <= w_wlast || w_rlast;
        end
    end

    assign bus.cmd_ready_o = r_state == IDLE;
    assign bus.wready_o    = r_state == WRITE;
    assign bus.mem_addr_o  = r_ptr;
    assign bus.mem_wdata_o = bus.wdata_i;
    assign bus.mem_we_o    = w_wfire;
    assign bus.rdata_o     = r_rdata;
    assign bus.rvalid_o    = r_rvalid;
    assign bus.done_o      = r_done;
endmodule
